// File: rtl/rabbit_dds_pkg.sv
// Shared constants and state encoding for the Rabbit-to-DDS command word path.
package rabbit_dds_pkg;

  localparam int unsigned WORD_BITS = 184;
  localparam int unsigned NUM_BYTES = WORD_BITS / 8;
  localparam int unsigned CSUM_BITS = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRecv  = 2'd1,
    StCheck = 2'd2
  } rx_state_e;

endpackage

// File: rtl/edge_sync.sv
// Multi-flop synchroniser for an asynchronous level, with single-cycle rise/fall pulses
// derived from the synchronised value against its one-cycle delayed copy.
module edge_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              prev_q, prev_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], d_i};
    prev_d = sync_q[Stages-1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level_o = sync_q[Stages-1];
  assign rise_o  = sync_q[Stages-1] & ~prev_q;
  assign fall_o  = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/rabbit_word_receiver.sv
// Receives a checksummed 184-bit command word from the Rabbit over a byte-wide strobe
// interface and holds the last good word for the sorter stage.
module rabbit_word_receiver
  import rabbit_dds_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 10000,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 ten_MHz_ext_2,
  input  logic                 reset,
  input  logic [7:0]           rabbit_data,
  input  logic                 rabbit_strobe,
  input  logic                 rabbit_frame,
  output logic [WORD_BITS-1:0] full_184_bit_in,
  output logic                 word_valid,
  output logic                 rabbit_ack,
  output logic                 frame_err,
  output logic [7:0]           good_count
);

  localparam int unsigned CntW = $clog2(NUM_BYTES + 1);
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CntW-1:0] CsumIdx = CntW'(NUM_BYTES);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  logic strobe_rise, strobe_level_unused, strobe_fall_unused;
  logic frame_rise, frame_fall, frame_level_unused;

  edge_sync #(
    .Stages (SYNC_STAGES)
  ) u_strobe_sync (
    .clk_i   (ten_MHz_ext_2),
    .rst_i   (reset),
    .d_i     (rabbit_strobe),
    .level_o (strobe_level_unused),
    .rise_o  (strobe_rise),
    .fall_o  (strobe_fall_unused)
  );

  edge_sync #(
    .Stages (SYNC_STAGES)
  ) u_frame_sync (
    .clk_i   (ten_MHz_ext_2),
    .rst_i   (reset),
    .d_i     (rabbit_frame),
    .level_o (frame_level_unused),
    .rise_o  (frame_rise),
    .fall_o  (frame_fall)
  );

  rx_state_e            state_q, state_d;
  logic [WORD_BITS-1:0] shift_q, shift_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [CSUM_BITS-1:0] csum_q, csum_d;
  logic [TmoW-1:0]      tmo_q, tmo_d;
  logic                 match_q, match_d;
  logic [WORD_BITS-1:0] word_q, word_d;
  logic                 valid_q, valid_d;
  logic                 ack_q, ack_d;
  logic                 err_q, err_d;
  logic [7:0]           good_q, good_d;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    tmo_d   = tmo_q;
    match_d = match_q;
    word_d  = word_q;
    valid_d = 1'b0;
    ack_d   = ack_q;
    err_d   = err_q;
    good_d  = good_q;

    case (state_q)
      StIdle: begin
        if (frame_rise) begin
          shift_d = '0;
          cnt_d   = '0;
          csum_d  = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
          state_d = StRecv;
        end
      end
      StRecv: begin
        // Priority: restart, then abort on frame drop, then byte, then timeout.
        if (frame_rise) begin
          shift_d = '0;
          cnt_d   = '0;
          csum_d  = '0;
          tmo_d   = '0;
          err_d   = 1'b0;
        end else if (frame_fall) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (strobe_rise) begin
          tmo_d = '0;
          ack_d = ~ack_q;
          if (cnt_q == CsumIdx) begin
            match_d = (rabbit_data == csum_q);
            state_d = StCheck;
          end else begin
            shift_d = {shift_q[WORD_BITS-CSUM_BITS-1:0], rabbit_data};
            csum_d  = csum_q ^ rabbit_data;
            cnt_d   = cnt_q + CntW'(1);
          end
        end else if (tmo_q == TmoLast) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StCheck: begin
        if (match_q) begin
          word_d  = shift_q;
          valid_d = 1'b1;
          good_d  = good_q + 8'd1;
        end else begin
          err_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge ten_MHz_ext_2) begin
    if (reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      tmo_q   <= '0;
      match_q <= 1'b0;
      word_q  <= '0;
      valid_q <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      good_q  <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      tmo_q   <= tmo_d;
      match_q <= match_d;
      word_q  <= word_d;
      valid_q <= valid_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      good_q  <= good_d;
    end
  end

  assign full_184_bit_in = word_q;
  assign word_valid      = valid_q;
  assign rabbit_ack      = ack_q;
  assign frame_err       = err_q;
  assign good_count      = good_q;

endmodule

// File: tb/tb_rabbit_word_receiver.sv
// Scoreboard bench for rabbit_word_receiver: stimulus pushes expected words, a monitor
// pops them on word_valid and tracks the held word and good count every cycle.
module tb_rabbit_word_receiver;
  import rabbit_dds_pkg::*;

  localparam int unsigned TIMEOUT_CYC = 10000;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [7:0]           rabbit_data;
  logic                 rabbit_strobe;
  logic                 rabbit_frame;
  logic [WORD_BITS-1:0] full_184_bit_in;
  logic                 word_valid;
  logic                 rabbit_ack;
  logic                 frame_err;
  logic [7:0]           good_count;

  always #5 clk = ~clk;

  rabbit_word_receiver #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (2)
  ) dut (
    .ten_MHz_ext_2   (clk),
    .reset           (reset),
    .rabbit_data     (rabbit_data),
    .rabbit_strobe   (rabbit_strobe),
    .rabbit_frame    (rabbit_frame),
    .full_184_bit_in (full_184_bit_in),
    .word_valid      (word_valid),
    .rabbit_ack      (rabbit_ack),
    .frame_err       (frame_err),
    .good_count      (good_count)
  );

  typedef struct packed {
    logic [WORD_BITS-1:0] word;
    logic [7:0]           cnt;
  } exp_t;

  exp_t                 exp_q[$];
  exp_t                 mon_e;
  int                   total = 0;
  int                   bad = 0;
  logic [WORD_BITS-1:0] held;
  logic [7:0]           held_cnt;
  logic [7:0]           pay[NUM_BYTES];
  logic [7:0]           exp_cnt;
  logic                 exp_ack;

  task automatic checkw(input string name, input logic [WORD_BITS-1:0] act,
                        input logic [WORD_BITS-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference: the word is the payload bytes concatenated first-byte-most-significant.
  function automatic logic [WORD_BITS-1:0] model_word();
    logic [WORD_BITS-1:0] w = '0;
    for (int i = 0; i < NUM_BYTES; i++) w = (w << 8) | WORD_BITS'(pay[i]);
    return w;
  endfunction

  function automatic logic [7:0] model_csum();
    logic [7:0] c = 8'h00;
    for (int i = 0; i < NUM_BYTES; i++) c = c ^ pay[i];
    return c;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      held     = '0;
      held_cnt = 8'd0;
      exp_q.delete();
    end else begin
      if (word_valid) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL spurious_valid: got word_valid=1 want no pulse at %0t", $time);
        end else begin
          mon_e    = exp_q.pop_front();
          held     = mon_e.word;
          held_cnt = mon_e.cnt;
        end
      end
      checkw("held_word", full_184_bit_in, held);
      check8("good_count", good_count, held_cnt);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rabbit_data   = b;
    rabbit_strobe = 1'b1;
    tick(3);
    rabbit_strobe = 1'b0;
    tick(3);
  endtask

  task automatic start_frame();
    rabbit_frame = 1'b1;
    tick(3);
  endtask

  task automatic end_frame();
    rabbit_frame = 1'b0;
    tick(4);
  endtask

  task automatic randomize_payload();
    for (int i = 0; i < NUM_BYTES; i++) pay[i] = 8'($urandom_range(0, 255));
  endtask

  task automatic good_frame(input string name);
    exp_cnt = exp_cnt + 8'd1;
    exp_q.push_back('{word: model_word(), cnt: exp_cnt});
    start_frame();
    for (int i = 0; i < NUM_BYTES; i++) send_byte(pay[i]);
    send_byte(model_csum());
    end_frame();
    check8({name, "_valid_seen"}, 8'(exp_q.size()), 8'd0);
    check8({name, "_err"}, {7'd0, frame_err}, 8'd0);
    check8({name, "_ack"}, {7'd0, rabbit_ack}, {7'd0, exp_ack});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish want finish before timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    rabbit_data   = 8'h00;
    rabbit_strobe = 1'b0;
    rabbit_frame  = 1'b0;
    exp_cnt       = 8'd0;
    exp_ack       = 1'b0;
    tick(3);
    checkw("rst_word", full_184_bit_in, '0);
    check8("rst_valid", {7'd0, word_valid}, 8'd0);
    check8("rst_ack", {7'd0, rabbit_ack}, 8'd0);
    check8("rst_err", {7'd0, frame_err}, 8'd0);
    check8("rst_count", good_count, 8'd0);
    reset = 1'b0;
    tick(2);

    // Directed good frame with payload 0x01..0x17.
    for (int i = 0; i < NUM_BYTES; i++) pay[i] = 8'(i + 1);
    good_frame("directed");

    // Wrong checksum byte: no update, error flagged.
    start_frame();
    for (int i = 0; i < NUM_BYTES; i++) send_byte(pay[i]);
    send_byte(model_csum() ^ 8'h5A);
    end_frame();
    check8("badcsum_err", {7'd0, frame_err}, 8'd1);
    check8("badcsum_count", good_count, exp_cnt);
    check8("badcsum_ack", {7'd0, rabbit_ack}, {7'd0, exp_ack});

    // Stall after 10 bytes until the timeout fires.
    randomize_payload();
    start_frame();
    for (int i = 0; i < 10; i++) send_byte(pay[i]);
    tick(TIMEOUT_CYC - 50);
    check8("stall_err_early", {7'd0, frame_err}, 8'd0);
    tick(100);
    check8("stall_err", {7'd0, frame_err}, 8'd1);
    check8("stall_ack", {7'd0, rabbit_ack}, {7'd0, exp_ack});
    end_frame();
    randomize_payload();
    good_frame("after_stall");

    // Frame drops after byte 5; later strobes must be ignored.
    start_frame();
    for (int i = 0; i < 5; i++) send_byte(pay[i]);
    exp_ack = ~exp_ack;
    end_frame();
    for (int i = 0; i < 3; i++) send_byte(8'hA5);
    check8("drop_err", {7'd0, frame_err}, 8'd1);
    check8("drop_ack", {7'd0, rabbit_ack}, {7'd0, exp_ack});
    check8("drop_count", good_count, exp_cnt);

    // Reset in the middle of a frame.
    randomize_payload();
    start_frame();
    for (int i = 0; i < 12; i++) send_byte(pay[i]);
    reset        = 1'b1;
    rabbit_frame = 1'b0;
    tick(1);
    checkw("midrst_word", full_184_bit_in, '0);
    check8("midrst_count", good_count, 8'd0);
    check8("midrst_err", {7'd0, frame_err}, 8'd0);
    check8("midrst_ack", {7'd0, rabbit_ack}, 8'd0);
    check8("midrst_valid", {7'd0, word_valid}, 8'd0);
    tick(1);
    reset   = 1'b0;
    exp_cnt = 8'd0;
    exp_ack = 1'b0;
    tick(3);
    randomize_payload();
    good_frame("after_rst");

    // 256 random good frames so the counter wraps.
    for (int f = 0; f < 256; f++) begin
      randomize_payload();
      good_frame("wrap");
    end
    check8("wrap_count", good_count, exp_cnt);

    tick(5);
    check8("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
